// File: rtl/trigger_capture_buffer.sv
// trigger_capture_buffer
//   Ring-buffer capture stage behind the LVDS receiver. ADC words are recorded
//   continuously into a 2^ADDR_W-deep RAM. A trigger freezes PRE_SAMPLES words
//   before it and POST_SAMPLES words starting with it. The frozen window is then
//   streamed out oldest-first over a valid/ready port.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE  0 | nothing recorded, waiting for ARM
//   FILL  1 | recording until PRE_SAMPLES words exist; TRIGGER ignored
//   ARMED 2 | recording continuously, waiting for the trigger sample
//   POST  3 | recording the post-trigger part of the window
//   READOUT4| streaming the window out, input samples dropped
//
// Ports:
//   sysclk, RESET      clock, asynchronous active-high reset
//   CBDATA, WENABLE    incoming sample and its qualifier
//   ARM, TRIGGER       capture start pulse, trigger level/pulse
//   RD_DATA/VALID/LAST readout stream, RD_READY is the consumer accept
//   STATE              current FSM encoding
//   OVERRUN            sticky: TRIGGER seen during POST or READOUT
module trigger_capture_buffer #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 8,
  parameter int PRE_SAMPLES  = 64,
  parameter int POST_SAMPLES = 192
) (
  input  logic              sysclk,
  input  logic              RESET,
  input  logic [DATA_W-1:0] CBDATA,
  input  logic              WENABLE,
  input  logic              ARM,
  input  logic              TRIGGER,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic              RD_LAST,
  output logic [2:0]        STATE,
  output logic              OVERRUN
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  PRE_C   = CNT_W'(PRE_SAMPLES);
  localparam logic [CNT_W-1:0]  POST_C  = CNT_W'(POST_SAMPLES);
  localparam logic [CNT_W-1:0]  TOTAL_C = CNT_W'(PRE_SAMPLES + POST_SAMPLES);
  localparam logic [ADDR_W-1:0] PRE_A   = ADDR_W'(PRE_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [CNT_W-1:0]    fillcnt_q, fillcnt_d;
  logic [CNT_W-1:0]    postcnt_q, postcnt_d;
  logic [CNT_W-1:0]    rdcnt_q, rdcnt_d;
  logic                pend_q, pend_d;
  logic                overrun_q, overrun_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                we;
  logic                rd_load;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    raddr_d    = raddr_q;
    fillcnt_d  = fillcnt_q;
    postcnt_d  = postcnt_q;
    rdcnt_d    = rdcnt_q;
    pend_d     = pend_q;
    overrun_d  = overrun_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    we         = 1'b0;
    rd_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ARM) begin
          state_d   = S_FILL;
          fillcnt_d = '0;
          overrun_d = 1'b0;
          pend_d    = 1'b0;
        end
      end

      S_FILL: begin
        if (WENABLE) begin
          we        = 1'b1;
          wptr_d    = wptr_q + 1'b1;
          fillcnt_d = fillcnt_q + 1'b1;
          if ((fillcnt_q + 1'b1) == PRE_C) state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (WENABLE) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (TRIGGER || pend_q) begin
            // The trigger sample lands at wptr_q, so the window starts
            // PRE_SAMPLES addresses behind it (modulo depth).
            raddr_d   = wptr_q - PRE_A;
            postcnt_d = CNT_W'(1);
            rdcnt_d   = '0;
            pend_d    = 1'b0;
            state_d   = (POST_SAMPLES == 1) ? S_READOUT : S_POST;
          end
        end else if (TRIGGER) begin
          // No sample this cycle; the next sample becomes the trigger sample.
          pend_d = 1'b1;
        end
      end

      S_POST: begin
        if (TRIGGER) overrun_d = 1'b1;
        if (WENABLE) begin
          we        = 1'b1;
          wptr_d    = wptr_q + 1'b1;
          postcnt_d = postcnt_q + 1'b1;
          if ((postcnt_q + 1'b1) == POST_C) state_d = S_READOUT;
        end
      end

      S_READOUT: begin
        if (TRIGGER) overrun_d = 1'b1;
        // The output register doubles as the RAM read register: it loads
        // whenever it is empty or being drained, giving one word per cycle
        // and a natural hold under backpressure.
        rd_load = (!rd_valid_q || RD_READY) && (rdcnt_q != TOTAL_C);
        if (rd_load) begin
          raddr_d    = raddr_q + 1'b1;
          rdcnt_d    = rdcnt_q + 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (rdcnt_q == (TOTAL_C - 1'b1));
        end else if (rd_valid_q && RD_READY) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
        if (rd_valid_q && RD_READY && rd_last_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      raddr_q    <= '0;
      fillcnt_q  <= '0;
      postcnt_q  <= '0;
      rdcnt_q    <= '0;
      pend_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      raddr_q    <= raddr_d;
      fillcnt_q  <= fillcnt_d;
      postcnt_q  <= postcnt_d;
      rdcnt_q    <= rdcnt_d;
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (we) mem_q[wptr_q] <= CBDATA;
  end

  always_ff @(posedge sysclk or posedge RESET) begin
    if (RESET) begin
      rd_data_q <= '0;
    end else if (rd_load) begin
      rd_data_q <= mem_q[raddr_q];
    end
  end

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign RD_LAST  = rd_last_q;
  assign STATE    = state_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_trigger_capture_buffer.sv
module tb_trigger_capture_buffer;

  logic        sysclk = 1'b0;
  logic        RESET  = 1'b1;
  logic [11:0] CBDATA = '0;
  logic        WENABLE = 1'b0;
  logic        ARM = 1'b0;
  logic        TRIGGER = 1'b0;
  logic [11:0] RD_DATA;
  logic        RD_VALID;
  logic        RD_READY = 1'b0;
  logic        RD_LAST;
  logic [2:0]  STATE;
  logic        OVERRUN;

  int checks = 0;
  int passed = 0;

  trigger_capture_buffer dut (
    .sysclk  (sysclk),
    .RESET   (RESET),
    .CBDATA  (CBDATA),
    .WENABLE (WENABLE),
    .ARM     (ARM),
    .TRIGGER (TRIGGER),
    .RD_DATA (RD_DATA),
    .RD_VALID(RD_VALID),
    .RD_READY(RD_READY),
    .RD_LAST (RD_LAST),
    .STATE   (STATE),
    .OVERRUN (OVERRUN)
  );

  always #5 sysclk = ~sysclk;

  // trig_n: sample with TRIGGER coincident; gap_n: TRIGGER in the empty cycle
  // after that sample; extra_n: second coincident trigger (POST overrun).
  typedef struct {
    int trig_n;
    int gap_n;
    int extra_n;
    int ready_mode;
    int exp_first;
    int exp_ovr;
  } cap_t;

  cap_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_arm();
    ARM = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    ARM = 1'b0;
    chk("arm_to_fill", int'(STATE), 1);
    chk("ovr_clr_on_arm", int'(OVERRUN), 0);
  endtask

  task automatic read_window(input int first, input int mode, input int stop_after);
    int k = 0;
    int cyc = 0;
    bit stall = 0;
    bit seen = 0;
    bit ready;
    logic [11:0] hd = '0;
    logic hl = 1'b0;
    while (k < 256 && cyc < 3000) begin
      ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (stall) begin
        chk("stall_data", int'(RD_DATA), int'(hd));
        chk("stall_last", int'(RD_LAST), int'(hl));
        chk("stall_valid", int'(RD_VALID), 1);
      end
      if (mode == 0 && seen) chk("no_bubble", int'(RD_VALID), 1);
      if (RD_VALID) seen = 1;
      if (RD_VALID && ready) begin
        chk("word", int'(RD_DATA), first + k);
        chk("last", int'(RD_LAST), int'(k == 255));
        k++;
      end
      stall = RD_VALID && !ready;
      hd = RD_DATA;
      hl = RD_LAST;
      RD_READY = ready;
      @(posedge sysclk);
      @(negedge sysclk);
      cyc++;
      if (stop_after != 0 && k == stop_after) break;
    end
    RD_READY = 1'b0;
    if (stop_after == 0) begin
      chk("word_count", k, 256);
      chk("end_state_idle", int'(STATE), 0);
      chk("end_valid_low", int'(RD_VALID), 0);
      chk("end_last_low", int'(RD_LAST), 0);
    end else begin
      chk("partial_count", k, stop_after);
    end
  endtask

  task automatic run_capture(input cap_t c, input int stop_after);
    int n = 0;
    bit hit = 0;
    do_arm();
    while (!hit && n < 1000) begin
      if (STATE == 3'd4) begin
        hit = 1;
      end else begin
        WENABLE = 1'b1;
        CBDATA  = 12'(n);
        TRIGGER = (n == c.trig_n) || (n == c.extra_n);
        @(posedge sysclk);
        @(negedge sysclk);
        WENABLE = 1'b0;
        TRIGGER = (n == c.gap_n);
        @(posedge sysclk);
        @(negedge sysclk);
        TRIGGER = 1'b0;
        n++;
      end
    end
    chk("reach_readout", int'(hit), 1);
    if (hit) begin
      // Window ends 191 samples after the trigger sample.
      chk("samples_written", n, c.exp_first + 256);
      read_window(c.exp_first, c.ready_mode, stop_after);
      if (stop_after == 0) chk("overrun", int'(OVERRUN), c.exp_ovr);
    end
  endtask

  initial begin
    //            trig  gap  extra  ready first ovr
    tbl[0] = '{  100,  -1,   -1,    0,   36,  0};
    tbl[1] = '{  300,  -1,   -1,    0,  236,  0};
    tbl[2] = '{   10,  70,   -1,    0,    7,  0};
    tbl[3] = '{  100,  -1,   -1,    1,   36,  0};
    tbl[4] = '{  100,  -1,  150,    0,   36,  1};
    tbl[5] = '{  120,  -1,   -1,    1,   56,  0};

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_state", int'(STATE), 0);
    chk("rst_valid", int'(RD_VALID), 0);
    chk("rst_last", int'(RD_LAST), 0);
    chk("rst_data", int'(RD_DATA), 0);
    chk("rst_overrun", int'(OVERRUN), 0);
    RESET = 1'b0;

    // WENABLE and TRIGGER in IDLE must not start anything.
    WENABLE = 1'b1;
    TRIGGER = 1'b1;
    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    WENABLE = 1'b0;
    TRIGGER = 1'b0;
    chk("idle_ignores_inputs", int'(STATE), 0);

    for (int i = 0; i < 6; i++) run_capture(tbl[i], 0);

    // Reset in the middle of a readout.
    run_capture(tbl[0], 50);
    RESET = 1'b1;
    #1;
    chk("midrst_valid", int'(RD_VALID), 0);
    chk("midrst_state", int'(STATE), 0);
    chk("midrst_last", int'(RD_LAST), 0);
    chk("midrst_data", int'(RD_DATA), 0);
    @(negedge sysclk);
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      WENABLE = 1'b1;
      CBDATA  = 12'(i);
      TRIGGER = 1'b1;
      @(posedge sysclk);
      @(negedge sysclk);
      chk("post_rst_idle", int'(STATE), 0);
    end
    WENABLE = 1'b0;
    TRIGGER = 1'b0;
    chk("post_rst_no_valid", int'(RD_VALID), 0);

    // A fresh ARM after reset captures normally.
    run_capture(tbl[0], 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
